// File: rtl/jackal_rotary_ctrl_if.sv
// Player-control bundle between the input decoder and the rotary joystick generator.
// master drives buttons, sticks and mode bits; slave returns the rotary codes.
interface jackal_rotary_ctrl_if;
  logic       fast;
  logic       abs_en;
  logic       disable_rot;
  logic       p1_rot_l;
  logic       p1_rot_r;
  logic [3:0] p1_dir;
  logic       p2_rot_l;
  logic       p2_rot_r;
  logic [3:0] p2_dir;
  logic [7:0] p1_rotary;
  logic [7:0] p2_rotary;
  logic       p1_moving;
  logic       p2_moving;

  modport master (
    output fast, abs_en, disable_rot,
    output p1_rot_l, p1_rot_r, p1_dir,
    output p2_rot_l, p2_rot_r, p2_dir,
    input  p1_rotary, p2_rotary, p1_moving, p2_moving
  );

  modport slave (
    input  fast, abs_en, disable_rot,
    input  p1_rot_l, p1_rot_r, p1_dir,
    input  p2_rot_l, p2_rot_r, p2_dir,
    output p1_rotary, p2_rotary, p1_moving, p2_moving
  );
endinterface

// File: rtl/jackal_rotary_ctrl.sv
// Two independent 8-position rotary joystick generators for the Jackal core, stepped
// once per prescaler tick by rotate buttons or by tracking an 8-way stick direction.
module jackal_rotary_ctrl #(
  parameter int DIV_BITS = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  jackal_rotary_ctrl_if.slave  rot
);

  logic [DIV_BITS-1:0] div_reg;
  logic                tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  assign tick = rot.fast ? (div_reg[DIV_BITS-2:0] == '0) : (div_reg == '0);

  logic [1:0] rot_l;
  logic [1:0] rot_r;
  logic [3:0] dir [2];

  assign rot_l  = {rot.p2_rot_l, rot.p1_rot_l};
  assign rot_r  = {rot.p2_rot_r, rot.p1_rot_r};
  assign dir[0] = rot.p1_dir;
  assign dir[1] = rot.p2_dir;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_player
      logic [2:0] pos_reg;
      logic [2:0] pos_next;
      logic [2:0] target;
      logic       target_valid;
      logic [2:0] delta;
      logic [7:0] rotary_reg;
      logic       moving_reg;

      // dir is {up, down, left, right}; positions count counter-clockwise from up.
      always_comb begin
        target       = 3'd0;
        target_valid = 1'b1;
        case (dir[gi])
          4'b1000: target = 3'd0;
          4'b1010: target = 3'd1;
          4'b0010: target = 3'd2;
          4'b0110: target = 3'd3;
          4'b0100: target = 3'd4;
          4'b0101: target = 3'd5;
          4'b0001: target = 3'd6;
          4'b1001: target = 3'd7;
          default: target_valid = 1'b0;
        endcase
      end

      assign delta = target - pos_reg;

      // Single steps only: the game drops codes that skip a position.
      always_comb begin
        pos_next = pos_reg;
        if (tick && !rot.disable_rot) begin
          if (rot_l[gi]) begin
            pos_next = pos_reg + 3'd1;
          end else if (rot_r[gi]) begin
            pos_next = pos_reg - 3'd1;
          end else if (rot.abs_en && target_valid && (delta != 3'd0)) begin
            pos_next = (delta <= 3'd4) ? pos_reg + 3'd1 : pos_reg - 3'd1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          pos_reg    <= 3'd0;
          rotary_reg <= 8'h01;
          moving_reg <= 1'b0;
        end else begin
          pos_reg    <= pos_next;
          rotary_reg <= rot.disable_rot ? 8'hFF : (8'h01 << pos_next);
          moving_reg <= rot.abs_en && target_valid && (delta != 3'd0) && !rot.disable_rot;
        end
      end
    end
  endgenerate

  assign rot.p1_rotary = g_player[0].rotary_reg;
  assign rot.p2_rotary = g_player[1].rotary_reg;
  assign rot.p1_moving = g_player[0].moving_reg;
  assign rot.p2_moving = g_player[1].moving_reg;

endmodule

// File: tb/tb_jackal_rotary_ctrl.sv
// Directed bench for jackal_rotary_ctrl with DIV_BITS=4 (slow tick 16 clocks, fast 8).
// After reset release, ticks land on edges 1, 17, 33... (slow) or 1, 9, 17... (fast).
module tb_jackal_rotary_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  jackal_rotary_ctrl_if bus ();

  jackal_rotary_ctrl #(.DIV_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .rot   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %-12s obs=%h exp=%h ok", tag, obs, exp);
    end else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic clear_inputs();
    bus.fast        = 1'b0;
    bus.abs_en      = 1'b0;
    bus.disable_rot = 1'b0;
    bus.p1_rot_l    = 1'b0;
    bus.p1_rot_r    = 1'b0;
    bus.p1_dir      = 4'b0000;
    bus.p2_rot_l    = 1'b0;
    bus.p2_rot_r    = 1'b0;
    bus.p2_dir      = 4'b0000;
  endtask

  // Leaves the bench just after edge E0 with reset low; E1 is the first tick.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    edges(2);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    reset  = 1'b1;
    clear_inputs();

    // 1: reset state and idle
    do_reset();
    chk("rst_state", {bus.p1_rotary, bus.p2_rotary, 6'd0, bus.p1_moving, bus.p2_moving},
        {8'h01, 8'h01, 8'h00});
    for (int i = 0; i < 40; i++) begin
      edges(1);
      chk("idle", {bus.p1_rotary, bus.p2_rotary, 6'd0, bus.p1_moving, bus.p2_moving},
          {8'h01, 8'h01, 8'h00});
    end

    // 2: rot_l held across 9 slow ticks, change lands 1 clock after each tick cycle
    do_reset();
    bus.p1_rot_l = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) edges(15);
      chk("rotl_before", {24'd0, bus.p1_rotary}, 32'(8'h01 << (i % 8)));
      edges(1);
      chk("rotl_after", {24'd0, bus.p1_rotary}, 32'(8'h01 << ((i + 1) % 8)));
      chk("rotl_p2", {24'd0, bus.p2_rotary}, 32'h01);
    end

    // 3: rot_r wraps downward, slow then fast spacing
    do_reset();
    bus.p1_rot_r = 1'b1;
    edges(1);
    chk("rotr_t1", {24'd0, bus.p1_rotary}, 32'h80);
    edges(15);
    chk("rotr_hold", {24'd0, bus.p1_rotary}, 32'h80);
    edges(1);
    chk("rotr_t2", {24'd0, bus.p1_rotary}, 32'h40);
    do_reset();
    bus.fast     = 1'b1;
    bus.p1_rot_r = 1'b1;
    edges(1);
    chk("fast_t1", {24'd0, bus.p1_rotary}, 32'h80);
    edges(7);
    chk("fast_hold", {24'd0, bus.p1_rotary}, 32'h80);
    edges(1);
    chk("fast_t2", {24'd0, bus.p1_rotary}, 32'h40);
    edges(8);
    chk("fast_t3", {24'd0, bus.p1_rotary}, 32'h20);

    // 4a: absolute, target R=6 from 0 goes the short way 0->7->6
    do_reset();
    bus.abs_en = 1'b1;
    bus.p1_dir = 4'b0001;
    edges(1);
    chk("abs_r_t1", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b1, 8'h80});
    edges(16);
    chk("abs_r_t2", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b1, 8'h40});
    edges(1);
    chk("abs_r_stop", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h40});
    edges(16);
    chk("abs_r_hold", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h40});
    chk("abs_r_p2", {23'd0, bus.p2_moving, bus.p2_rotary}, {23'd0, 1'b0, 8'h01});

    // 4b: target D=4 is a tie and goes upward; P2 tracks L=2 independently
    do_reset();
    bus.abs_en = 1'b1;
    bus.p1_dir = 4'b0100;
    bus.p2_dir = 4'b0010;
    edges(1);
    chk("abs_d_t1", {24'd0, bus.p1_rotary}, 32'h02);
    edges(16);
    chk("abs_d_t2", {24'd0, bus.p1_rotary}, 32'h04);
    chk("abs_l_p2", {23'd0, bus.p2_moving, bus.p2_rotary}, {23'd0, 1'b1, 8'h04});
    edges(16);
    chk("abs_d_t3", {24'd0, bus.p1_rotary}, 32'h08);
    chk("abs_l_p2hold", {23'd0, bus.p2_moving, bus.p2_rotary}, {23'd0, 1'b0, 8'h04});
    edges(16);
    chk("abs_d_t4", {24'd0, bus.p1_rotary}, 32'h10);
    edges(16);
    chk("abs_d_done", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h10});

    // 5: invalid U+D target holds; button beats stick
    do_reset();
    bus.abs_en = 1'b1;
    bus.p1_dir = 4'b1100;
    edges(1);
    chk("ud_t1", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h01});
    edges(16);
    chk("ud_t2", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h01});
    bus.p1_dir   = 4'b0001;
    bus.p1_rot_l = 1'b1;
    edges(16);
    chk("btn_wins", {24'd0, bus.p1_rotary}, 32'h02);

    // 6: disable freezes pos, then reset mid-tracking
    do_reset();
    bus.fast     = 1'b1;
    bus.p1_rot_l = 1'b1;
    edges(17);
    chk("dis_pre", {24'd0, bus.p1_rotary}, 32'h08);
    bus.p1_rot_l    = 1'b0;
    bus.disable_rot = 1'b1;
    edges(1);
    chk("dis_on", {bus.p1_rotary, bus.p2_rotary, 6'd0, bus.p1_moving, bus.p2_moving},
        {8'hFF, 8'hFF, 8'h00});
    bus.p1_rot_l = 1'b1;
    edges(23);
    chk("dis_held", {bus.p1_rotary, bus.p2_rotary, 6'd0, bus.p1_moving, bus.p2_moving},
        {8'hFF, 8'hFF, 8'h00});
    bus.p1_rot_l    = 1'b0;
    bus.disable_rot = 1'b0;
    edges(1);
    chk("dis_off", {16'd0, bus.p1_rotary, bus.p2_rotary}, {16'd0, 8'h08, 8'h01});
    bus.abs_en = 1'b1;
    bus.p1_dir = 4'b0001;
    edges(7);
    chk("track_step", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b1, 8'h10});
    reset = 1'b1;
    edges(1);
    chk("mid_reset", {23'd0, bus.p1_moving, bus.p1_rotary}, {23'd0, 1'b0, 8'h01});
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
